// File: rtl/input_conditioner.sv
// Synchroniser plus four-state debouncer for a raw asynchronous level.
// q, rise and fall are all registered and change together on the qualifying edge.
module input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    input  logic enable,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   q_q, q_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   diff;

    assign synced = sync_q[SYNC_STAGES-1];
    assign diff   = synced != q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        q_d     = q_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LO, STABLE_HI: begin
                count_d = '0;
                if (enable && diff) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = q_q ? STABLE_LO : STABLE_HI;
                        q_d     = ~q_q;
                        rise_d  = ~q_q;
                        fall_d  = q_q;
                    end else begin
                        state_d = q_q ? PEND_LO : PEND_HI;
                        count_d = CW'(1);
                    end
                end
            end
            PEND_HI, PEND_LO: begin
                // A bounce back or a disable abandons the window entirely.
                if (!enable || !diff) begin
                    state_d = q_q ? STABLE_HI : STABLE_LO;
                    count_d = '0;
                end else if (count_q >= CNT_LAST) begin
                    state_d = q_q ? STABLE_LO : STABLE_HI;
                    count_d = '0;
                    q_d     = ~q_q;
                    rise_d  = ~q_q;
                    fall_d  = q_q;
                end else if (count_q != CNT_MAX) begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE_LO;
                count_d = '0;
                q_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STABLE_LO;
            count_q <= '0;
            q_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == PEND_HI) || (state_q == PEND_LO);

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench: stimulus queues expected pulses, a negedge monitor pops and compares them.
module tb_input_conditioner;
    localparam int SS  = 2;
    localparam int DB  = 4;
    localparam int LAT = SS + DB;

    logic clk = 1'b0;
    logic rst, d_async, enable;
    logic q, rise, fall, busy;

    input_conditioner #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .d_async(d_async), .enable(enable),
        .q(q), .rise(rise), .fall(fall), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {bit is_rise; int cyc;} ev_t;
    ev_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (edge %0d, t=%0t)", name, act, req, cyc, $time);
        end
    endtask

    task automatic step(input logic v, input bit expect_pulse);
        d_async = v;
        if (expect_pulse) exp_q.push_back('{v, cyc + LAT});
    endtask

    // Monitor: per-cycle pulse/q consistency plus scoreboard of expected pulses.
    logic prev_q = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            check("rise_matches_q_edge", 32'(rise), 32'(1'(q & ~prev_q)));
            check("fall_matches_q_edge", 32'(fall), 32'(1'(~q & prev_q)));
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("missed_pulse_edge", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (rise || fall) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'(1), 32'(0));
                end else begin
                    ev_t ev;
                    ev = exp_q.pop_front();
                    check("pulse_edge", cyc, ev.cyc);
                    check("pulse_dir_rise", 32'(rise), 32'(ev.is_rise));
                end
            end
        end
        prev_q = q;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, required finish before 50000 ns");
        $fatal(1);
    end

    initial begin
        int bc;
        // Reset with d_async already high: behaves as a normal 0->1 step after release.
        rst = 1'b1; d_async = 1'b1; enable = 1'b1;
        #3;
        check("rst_q", 32'(q), 32'(0));
        check("rst_rise", 32'(rise), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        #5;
        check("rst_sync_after_edge", 32'(dut.sync_q), 32'(0));
        check("rst_count", 32'(dut.count_q), 32'(0));
        exp_q.push_back('{1'b1, 1 + LAT});
        #4 rst = 1'b0;
        @(negedge clk);
        repeat (10) @(negedge clk);
        check("q_after_reset_step", 32'(q), 32'(1));

        // Clean steps: fall, rise, fall.
        step(1'b0, 1'b1); repeat (20) @(negedge clk);
        check("clean_fall_q", 32'(q), 32'(0));
        step(1'b1, 1'b1); repeat (20) @(negedge clk);
        check("clean_rise_q", 32'(q), 32'(1));
        step(1'b0, 1'b1); repeat (20) @(negedge clk);
        check("clean_fall2_q", 32'(q), 32'(0));

        // Two-cycle glitch: short pending window, no pulse.
        step(1'b1, 1'b0); repeat (2) @(negedge clk);
        step(1'b0, 1'b0);
        bc = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy) bc++;
        end
        check("glitch_busy_in_1_to_2", 32'(bc >= 1 && bc <= 2), 32'(1));
        check("glitch_q", 32'(q), 32'(0));

        // Bounce 3 cycles per level, then settle high: single rise from final edge.
        for (int k = 0; k < 4; k++) begin
            step((k % 2) == 0, 1'b0);
            repeat (3) @(negedge clk);
        end
        step(1'b1, 1'b1); repeat (20) @(negedge clk);
        check("bounce_q", 32'(q), 32'(1));

        // Reset mid PEND_HI with count = 2.
        step(1'b0, 1'b1); repeat (20) @(negedge clk);
        step(1'b1, 1'b0); repeat (4) @(negedge clk);
        check("pend_count_before_rst", 32'(dut.count_q), 32'(2));
        check("pend_busy_before_rst", 32'(busy), 32'(1));
        #1 rst = 1'b1;
        #1;
        check("midrst_q", 32'(q), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_count", 32'(dut.count_q), 32'(0));
        check("midrst_rise", 32'(rise), 32'(0));
        #2 rst = 1'b0;
        exp_q.push_back('{1'b1, cyc + LAT});
        repeat (20) @(negedge clk);
        check("after_midrst_q", 32'(q), 32'(1));

        // Enable dropped for 5 cycles during PEND_HI.
        step(1'b0, 1'b1); repeat (20) @(negedge clk);
        step(1'b1, 1'b0); repeat (4) @(negedge clk);
        check("en_pend_busy", 32'(busy), 32'(1));
        enable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("disabled_busy", 32'(busy), 32'(0));
            check("disabled_q", 32'(q), 32'(0));
        end
        enable = 1'b1;
        exp_q.push_back('{1'b1, cyc + DB});
        repeat (20) @(negedge clk);
        check("after_enable_q", 32'(q), 32'(1));

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
